udp_cntr_reg_slave: RTL and testbench

UDP_CNTR_REG_SLAVE -- requirements
Module: udp_cntr_reg_slave

---
 rtl/udp_cntr_reg_slave_pkg.sv | 7 +
 rtl/udp_cntr_bank.sv | 35 +++
 rtl/udp_cntr_reg_slave.sv | 102 ++++++++++
 tb/tb_udp_cntr_reg_slave.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/udp_cntr_reg_slave_pkg.sv
// udp_cntr_reg_slave_pkg: ring width defaults and the bad-address read value shared by the counter slave
package udp_cntr_reg_slave_pkg;
    localparam int DEF_ADDR_WIDTH = 23;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SRC_WIDTH  = 2;
    localparam logic [31:0] BAD_ADDR_DATA = 32'hdead_beef;
endpackage

// File: rtl/udp_cntr_bank.sv
// udp_cntr_bank: counter array; write beats clear-on-read, which beats increment
module udp_cntr_bank
    import udp_cntr_reg_slave_pkg::*;
#(
    parameter int NUM_CNTRS  = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CNTRS-1:0]            inc,
    input  logic [NUM_CNTRS-1:0]            wr,
    input  logic [NUM_CNTRS-1:0]            clr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic [NUM_CNTRS*DATA_WIDTH-1:0] cntrs
);
    logic [NUM_CNTRS-1:0][DATA_WIDTH-1:0] cnt;

    assign cntrs = cnt;

    // A clear coinciding with an increment keeps that increment, so the counter lands on 1
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CNTRS; i++) begin
                if (wr[i])
                    cnt[i] <= wr_data;
                else if (clr[i])
                    cnt[i] <= {{(DATA_WIDTH-1){1'b0}}, inc[i]};
                else if (inc[i])
                    cnt[i] <= cnt[i] + DATA_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/udp_cntr_reg_slave.sv
// udp_cntr_reg_slave: register-ring slave exposing hardware counters and software R/W registers
module udp_cntr_reg_slave
    import udp_cntr_reg_slave_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int SRC_WIDTH        = DEF_SRC_WIDTH,
    parameter int TAG              = 0,
    parameter int BLOCK_ADDR_WIDTH = 4,
    parameter int NUM_CNTRS        = 4,
    parameter int NUM_SW_REGS      = 4,
    parameter int RESET_ON_READ    = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              reg_req_in,
    input  logic                              reg_ack_in,
    input  logic                              reg_rd_wr_L_in,
    input  logic [ADDR_WIDTH-1:0]             reg_addr_in,
    input  logic [DATA_WIDTH-1:0]             reg_data_in,
    input  logic [SRC_WIDTH-1:0]              reg_src_in,
    output logic                              reg_req_out,
    output logic                              reg_ack_out,
    output logic                              reg_rd_wr_L_out,
    output logic [ADDR_WIDTH-1:0]             reg_addr_out,
    output logic [DATA_WIDTH-1:0]             reg_data_out,
    output logic [SRC_WIDTH-1:0]              reg_src_out,
    input  logic [NUM_CNTRS-1:0]              cntr_inc,
    output logic [NUM_SW_REGS*DATA_WIDTH-1:0] sw_regs
);
    localparam int TAG_W = ADDR_WIDTH - BLOCK_ADDR_WIDTH;

    logic                                   hit;
    logic                                   rd;
    int                                     off;
    logic [NUM_CNTRS-1:0]                   cntr_wr;
    logic [NUM_CNTRS-1:0]                   cntr_clr;
    logic [NUM_CNTRS*DATA_WIDTH-1:0]        cntrs;
    logic [NUM_SW_REGS-1:0][DATA_WIDTH-1:0] sw_q;
    logic [DATA_WIDTH-1:0]                  rd_data;

    assign hit     = reg_req_in && !reg_ack_in && reg_addr_in[ADDR_WIDTH-1:BLOCK_ADDR_WIDTH] == TAG_W'(TAG);
    assign rd      = reg_rd_wr_L_in;
    assign off     = 32'(reg_addr_in[BLOCK_ADDR_WIDTH-1:0]);
    assign sw_regs = sw_q;

    // Offsets matching neither a counter nor a register fall through to the bad-address value
    always_comb begin
        rd_data  = DATA_WIDTH'(BAD_ADDR_DATA);
        cntr_wr  = '0;
        cntr_clr = '0;
        for (int i = 0; i < NUM_CNTRS; i++) begin
            if (off == i) begin
                rd_data     = cntrs[i*DATA_WIDTH +: DATA_WIDTH];
                cntr_wr[i]  = hit && !rd;
                cntr_clr[i] = hit && rd && RESET_ON_READ != 0;
            end
        end
        for (int i = 0; i < NUM_SW_REGS; i++)
            if (off == NUM_CNTRS + i) rd_data = sw_q[i];
    end

    udp_cntr_bank #(
        .NUM_CNTRS (NUM_CNTRS),
        .DATA_WIDTH(DATA_WIDTH)
    ) bank (
        .clk    (clk),
        .reset  (reset),
        .inc    (cntr_inc),
        .wr     (cntr_wr),
        .clr    (cntr_clr),
        .wr_data(reg_data_in),
        .cntrs  (cntrs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SW_REGS; i++)
                if (hit && !rd && off == NUM_CNTRS + i) sw_q[i] <= reg_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in || hit;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= (hit && rd) ? rd_data : reg_data_in;
            reg_src_out     <= reg_src_in;
        end
    end
endmodule

// File: tb/tb_udp_cntr_reg_slave.sv
// tb_udp_cntr_reg_slave: directed and random ring traffic against a transaction-level model,
// run on a plain instance and a clear-on-read instance side by side
module tb_udp_cntr_reg_slave;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int NC = 4;
    localparam int NS = 4;
    localparam logic [DW-1:0] BAD = 32'hdead_beef;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0, ack = 1'b0, rw = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [SW-1:0] src = '0;
    logic [NC-1:0] inc = '0;

    logic req0, ack0, rw0, req1, ack1, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic [SW-1:0] src0, src1;
    logic [NS*DW-1:0] sw0, sw1;

    logic [DW-1:0] m_cnt [2][NC];
    logic [DW-1:0] m_sw [NS];
    logic [AW+4:0] exp_ring;
    logic [DW-1:0] exp_data [2];
    logic [NS*DW-1:0] flat;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    udp_cntr_reg_slave u0 (
        .clk(clk), .reset(reset),
        .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rw),
        .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
        .reg_req_out(req0), .reg_ack_out(ack0), .reg_rd_wr_L_out(rw0),
        .reg_addr_out(addr0), .reg_data_out(data0), .reg_src_out(src0),
        .cntr_inc(inc), .sw_regs(sw0)
    );

    udp_cntr_reg_slave #(.RESET_ON_READ(1)) u1 (
        .clk(clk), .reset(reset),
        .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rw),
        .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
        .reg_req_out(req1), .reg_ack_out(ack1), .reg_rd_wr_L_out(rw1),
        .reg_addr_out(addr1), .reg_data_out(data1), .reg_src_out(src1),
        .cntr_inc(inc), .sw_regs(sw1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One ring transaction: predict outputs from the model, clock it, compare, then advance the model
    task automatic step(input logic rq, input logic ak, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [NC-1:0] in_c);
        logic hit, rst;
        int o;
        req = rq; ack = ak; rw = r; addr = a; data = d; src = s; inc = in_c;
        rst = reset;
        hit = rq && !ak && a[AW-1:4] == '0;
        o = int'(a[3:0]);
        for (int m = 0; m < 2; m++) begin
            exp_data[m] = d;
            if (hit && r) exp_data[m] = (o < NC) ? m_cnt[m][o] : (o < NC + NS) ? m_sw[o-NC] : BAD;
            if (rst) exp_data[m] = '0;
        end
        exp_ring = rst ? '0 : {rq, ak | hit, r, a, s};
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NC; i++) begin
                if (rst) m_cnt[m][i] = '0;
                else if (hit && !r && o == i) m_cnt[m][i] = d;
                else if (m == 1 && hit && r && o == i) m_cnt[m][i] = in_c[i] ? 1 : 0;
                else if (in_c[i]) m_cnt[m][i] = m_cnt[m][i] + 1;
            end
        for (int i = 0; i < NS; i++) begin
            if (rst) m_sw[i] = '0;
            else if (hit && !r && o == NC + i) m_sw[i] = d;
            flat[i*DW +: DW] = m_sw[i];
        end
        check("ring0", {req0, ack0, rw0, addr0, src0}, exp_ring);
        check("ring1", {req1, ack1, rw1, addr1, src1}, exp_ring);
        check("data0", data0, exp_data[0]);
        check("data1", data1, exp_data[1]);
        check("sw0", sw0, flat);
        check("sw1", sw1, flat);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) m_sw[i] = '0;
        for (int m = 0; m < 2; m++) for (int i = 0; i < NC; i++) m_cnt[m][i] = '0;
        reset = 1'b1;
        step(1, 0, 0, AW'(NC), 32'h55, 1, '1);
        step(1, 0, 1, AW'(1), 32'h0, 2, '1);
        check("rst_ack", ack0, 1'b0);
        check("rst_sw", sw0, '0);
        reset = 1'b0;
        step(1, 0, 0, AW'(NC), 32'hcafe, 1, '0);
        check("first_ack", ack0, 1'b1);
        check("first_sw", sw0[DW-1:0], 32'hcafe);
        repeat (3) step(0, 0, 0, '0, '0, 0, 4'b0010);
        step(1, 0, 1, AW'(1), '0, 0, '0);
        check("inc3_ack", ack0, 1'b1);
        check("inc3_data", data0, 32'd3);
        step(1, 0, 0, AW'(NC + 2), 32'h1234_5678, 0, '0);
        step(1, 0, 1, AW'(NC + 2), '0, 0, '0);
        check("swrd_data", data0, 32'h1234_5678);
        check("swrd_slice", sw0[2*DW +: DW], 32'h1234_5678);
        step(1, 0, 0, 23'h7f0001, 32'haaaa, 3, '0);
        check("miss_ring", {req0, ack0, rw0, addr0, src0}, {3'b100, 23'h7f0001, 2'd3});
        check("miss_data", data0, 32'haaaa);
        step(1, 1, 0, AW'(NC + 1), 32'hbeef, 0, '0);
        check("acked_data", data0, 32'hbeef);
        check("acked_sw", sw0[DW +: DW], 32'h0);
        step(1, 0, 1, AW'(15), '0, 1, '0);
        check("bad_ack", ack0, 1'b1);
        check("bad_data", data0, BAD);
        step(1, 0, 0, AW'(2), 32'hffff_ffff, 0, 4'b0100);
        step(0, 0, 0, '0, '0, 0, 4'b0100);
        step(1, 0, 1, AW'(2), '0, 0, '0);
        check("wrap0", data0, 32'h0);
        check("wrap1", data1, 32'h0);
        step(1, 0, 0, AW'(0), 32'd5, 0, '0);
        step(1, 0, 1, AW'(0), '0, 0, 4'b0001);
        check("ror_pre0", data0, 32'd5);
        check("ror_pre1", data1, 32'd5);
        step(1, 0, 1, AW'(0), '0, 0, '0);
        check("ror_post0", data0, 32'd6);
        check("ror_post1", data1, 32'd1);
        for (int n = 0; n < 1500; n++) begin
            reset = $urandom_range(0, 99) == 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
                 $urandom, SW'($urandom), NC'($urandom));
        end
        reset = 1'b0;
        step(0, 0, 0, '0, '0, 0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
